dkey_checker: RTL
=================

Name: dkey_checker

Overview:
- Unlock side of the dkey button protocol: the user enters KEY_LEN 2-bit digits, each latched from p_nbtn on a debounced set_nbtn press, and the block compares the entered code against a stored key.
- Drives leds to show OPEN, FAIL, LEARN and ALARM.
- While OPEN, a learn button lets the user overwrite the stored key with a new KEY_LEN-digit sequence entered the same way.
- Top-level block for the icestick dkey project.

Parameters:
- KEY_LEN, 4: digits per key (≥2).
- KEY_INIT, 8'h1B: reset key, 2*KEY_LEN bits; entry i in bits [2i+1:2i]; default digits 3,2,1,0.
- COUNT_WIDTH, 24: width of hold/blink counter.
- MAX_COUNT, 6000000: OPEN/FAIL hold time and ALARM blink half-period, in clk cycles.
- BNT_DEB_COUNT, 120000: debounce stable-cycle count.

Ports:
- clk, input, 1: system clock.
- rst_nbtn, input, 1: asynchronous active-low reset.
- set_nbtn, input, 1: digit-enter button, active low.
- learn_nbtn, input, 1: learn button, active low.
- p_nbtn, input, 2: digit switches, active low; digit = ~p_nbtn.
- leds, output, 2: status.

Behaviour:
- Reset (async assert, sync-safe deassert): state=LOCKED, index=0, mismatch=0, fail_cnt=0, key=KEY_INIT, counter=0, leds=2'b00.
- Inputs pass through 2-flop synchronizers.
- Debounce, applied separately to set_nbtn and learn_nbtn:
  - A press pulse (1 cycle) fires when the synchronized level has been low for BNT_DEB_COUNT consecutive cycles.
  - Re-arm requires BNT_DEB_COUNT consecutive high cycles.
  - Holding the button gives exactly one pulse.
- Digit capture: digit = ~p_nbtn_sync, sampled in the press-pulse cycle.
- LOCKED, leds=00:
  - Each set pulse compares digit to key[index]; any mismatch sets mismatch; index++.
  - On the KEY_LEN-th pulse, the next state is OPEN if mismatch=0 and the current digit matches, else FAIL.
  - In both cases index, mismatch and counter clear.
  - learn pulses are ignored.
- OPEN, leds=01:
  - Counts to MAX_COUNT-1, then goes to LOCKED.
  - Clears fail_cnt on entry.
  - A learn pulse enters LEARN with index=0 and counter=0.
  - set pulses are ignored.
  - If learn and set pulse in the same cycle, learn wins.
- FAIL, leds=10:
  - Counts to MAX_COUNT-1, then goes to LOCKED.
  - fail_cnt increments (saturating at 3) on entry.
  - All pulses are ignored.
- LEARN, leds=11:
  - Each set pulse writes digit into key[index]; index++.
  - After the KEY_LEN-th write, goes to LOCKED with index=0.
  - learn pulses are ignored.
  - No timeout.
- Index wraps only via these state exits; it never exceeds KEY_LEN-1.
- leds are registered and update the cycle after the state transition (1-cycle latency from the final press pulse).
- Reset in any state, including mid-entry or mid-learn, restores KEY_INIT; a partially learned key is discarded.

Optional Feature:
- Macro DKEY_LOCKOUT_EN.
- Defined:
  - FAIL entered with fail_cnt reaching 3 goes to ALARM instead of LOCKED when the hold expires.
  - ALARM: leds alternate 01/10, toggling every MAX_COUNT cycles (starting at 01).
  - All buttons are ignored; only rst_nbtn exits ALARM.
  - Success in OPEN clears fail_cnt.
- Undefined: no ALARM state or fail_cnt logic; FAIL always returns to LOCKED.

Test Plan (KEY_LEN=4, MAX_COUNT=10, BNT_DEB_COUNT=3, COUNT_WIDTH=10):
- Correct code: reset, then enter p_nbtn=00,01,10,11 (digits 3,2,1,0), each with set held low 16 cycles → leds=01 one cycle after the 4th pulse, held 10 cycles, then 00.
- Wrong digit: 00,01,11,11 → leds=10 for 10 cycles, then 00; the following correct code → 01.
- Learn and debounce:
  - While OPEN, pulse learn, then enter digits 0,1,0,1 → leds=11 during entry, 00 after the 4th.
  - The old code then gives 10; the new code gives 01.
  - A set glitch low for 2 cycles registers no digit.
- Mid-entry reset: after 2 correct digits, assert rst_nbtn → leds=00, index=0; 4 more correct digits → 01.
- Lockout, with DKEY_LOCKOUT_EN: 3 consecutive wrong codes → after the 3rd FAIL hold, leds toggle 01/10 every 10 cycles; correct code entry is ignored; rst_nbtn → 00.
- Ignored inputs:
  - Simultaneous set and learn pulse in OPEN → LEARN entered, no digit written.
  - learn in LOCKED → no effect.

Source files
------------

// File: rtl/dkey_checker.sv
// Unlock side of the dkey button protocol: debounced digit entry, key compare, learn mode.
// Optional lockout/ALARM behaviour is enabled by defining DKEY_LOCKOUT_EN.

module dkey_debounce #(
  parameter int DEB_COUNT = 120000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic press
);
  localparam int W = $clog2(DEB_COUNT + 1);

  logic         stable;
  logic [W-1:0] cnt;

  // stable flips only after DEB_COUNT consecutive cycles at the opposite level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (level != stable) begin
        if (cnt == W'(DEB_COUNT - 1)) begin
          stable <= level;
          cnt    <= '0;
          press  <= ~level;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module dkey_checker #(
  parameter int                    KEY_LEN       = 4,
  parameter logic [2*KEY_LEN-1:0]  KEY_INIT      = 8'h1B,
  parameter int                    COUNT_WIDTH   = 24,
  parameter int                    MAX_COUNT     = 6000000,
  parameter int                    BNT_DEB_COUNT = 120000
) (
  input  logic       clk,
  input  logic       rst_nbtn,
  input  logic       set_nbtn,
  input  logic       learn_nbtn,
  input  logic [1:0] p_nbtn,
  output logic [1:0] leds
);
  localparam int IDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(KEY_LEN - 1);
  localparam logic [COUNT_WIDTH-1:0] LAST_CNT = COUNT_WIDTH'(MAX_COUNT - 1);

`ifdef DKEY_LOCKOUT_EN
  typedef enum logic [2:0] {ST_LOCKED, ST_OPEN, ST_FAIL, ST_LEARN, ST_ALARM} state_t;
`else
  typedef enum logic [2:0] {ST_LOCKED, ST_OPEN, ST_FAIL, ST_LEARN} state_t;
`endif

  state_t                 state, state_n;
  logic [IDX_W-1:0]       index, index_n;
  logic                   mismatch, mismatch_n;
  logic [2*KEY_LEN-1:0]   key, key_n;
  logic [COUNT_WIDTH-1:0] counter, counter_n;
  logic [1:0]             leds_n;
`ifdef DKEY_LOCKOUT_EN
  logic [1:0]             fail_cnt, fail_cnt_n;
  logic                   phase, phase_n;
`endif

  // Reset asserts asynchronously and releases two clocks later
  logic [1:0] rst_sync;
  logic       rst_n;
  always_ff @(posedge clk or negedge rst_nbtn) begin
    if (!rst_nbtn) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic [3:0] in_meta, in_sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_meta <= 4'hF;
      in_sync <= 4'hF;
    end else begin
      in_meta <= {learn_nbtn, set_nbtn, p_nbtn};
      in_sync <= in_meta;
    end
  end

  logic       set_press, learn_press;
  logic [1:0] digit;
  assign digit = ~in_sync[1:0];

  dkey_debounce #(.DEB_COUNT(BNT_DEB_COUNT)) u_set_deb (
    .clk(clk), .rst_n(rst_n), .level(in_sync[2]), .press(set_press)
  );
  dkey_debounce #(.DEB_COUNT(BNT_DEB_COUNT)) u_learn_deb (
    .clk(clk), .rst_n(rst_n), .level(in_sync[3]), .press(learn_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_LOCKED;
      index    <= '0;
      mismatch <= 1'b0;
      key      <= KEY_INIT;
      counter  <= '0;
      leds     <= 2'b00;
`ifdef DKEY_LOCKOUT_EN
      fail_cnt <= 2'd0;
      phase    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      index    <= index_n;
      mismatch <= mismatch_n;
      key      <= key_n;
      counter  <= counter_n;
      leds     <= leds_n;
`ifdef DKEY_LOCKOUT_EN
      fail_cnt <= fail_cnt_n;
      phase    <= phase_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    index_n    = index;
    mismatch_n = mismatch;
    key_n      = key;
    counter_n  = counter;
`ifdef DKEY_LOCKOUT_EN
    fail_cnt_n = fail_cnt;
    phase_n    = phase;
`endif
    case (state)
      ST_LOCKED: begin
        if (set_press) begin
          if (digit != key[{index, 1'b0} +: 2]) mismatch_n = 1'b1;
          if (index == LAST_IDX) begin
            state_n    = (!mismatch && digit == key[{index, 1'b0} +: 2]) ? ST_OPEN : ST_FAIL;
            index_n    = '0;
            mismatch_n = 1'b0;
            counter_n  = '0;
`ifdef DKEY_LOCKOUT_EN
            if (state_n == ST_OPEN)    fail_cnt_n = 2'd0;
            else if (fail_cnt != 2'd3) fail_cnt_n = fail_cnt + 2'd1;
`endif
          end else begin
            index_n = index + 1'b1;
          end
        end
      end
      ST_OPEN: begin
        // learn outranks both a simultaneous set press and hold expiry
        if (learn_press) begin
          state_n   = ST_LEARN;
          index_n   = '0;
          counter_n = '0;
        end else if (counter == LAST_CNT) begin
          state_n   = ST_LOCKED;
          counter_n = '0;
        end else begin
          counter_n = counter + 1'b1;
        end
      end
      ST_FAIL: begin
        if (counter == LAST_CNT) begin
          counter_n = '0;
          state_n   = ST_LOCKED;
`ifdef DKEY_LOCKOUT_EN
          if (fail_cnt == 2'd3) begin
            state_n = ST_ALARM;
            phase_n = 1'b0;
          end
`endif
        end else begin
          counter_n = counter + 1'b1;
        end
      end
      ST_LEARN: begin
        if (set_press) begin
          key_n[{index, 1'b0} +: 2] = digit;
          if (index == LAST_IDX) begin
            state_n = ST_LOCKED;
            index_n = '0;
          end else begin
            index_n = index + 1'b1;
          end
        end
      end
`ifdef DKEY_LOCKOUT_EN
      ST_ALARM: begin
        if (counter == LAST_CNT) begin
          counter_n = '0;
          phase_n   = ~phase;
        end else begin
          counter_n = counter + 1'b1;
        end
      end
`endif
      default: state_n = ST_LOCKED;
    endcase
  end

  // leds follow the next state so they change one cycle after the deciding press
  always_comb begin
    leds_n = 2'b00;
    case (state_n)
      ST_OPEN:  leds_n = 2'b01;
      ST_FAIL:  leds_n = 2'b10;
      ST_LEARN: leds_n = 2'b11;
`ifdef DKEY_LOCKOUT_EN
      ST_ALARM: leds_n = phase_n ? 2'b10 : 2'b01;
`endif
      default:  leds_n = 2'b00;
    endcase
  end
endmodule
